wb_burst_master: RTL



---
 rtl/wb_burst_master_if.sv | 30 +++
 rtl/wb_burst_master.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_burst_master_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_burst_master_if
// Description : Wishbone B4 pipelined bus bundle between one initiator and
//               one target. The master modport is the initiator side.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_burst_master_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_o,
    input  dat_i, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_o,
    output dat_i, ack, err, stall
  );
endinterface
`default_nettype wire

// File: rtl/wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_burst_master
// Description : Wishbone B4 pipelined initiator. Turns one local command into
//               a burst of single-word transfers at incrementing addresses,
//               keeps a bounded number of requests in flight, honours STALL
//               and reports completion with an error summary.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_burst_master #(
  parameter int MAX_LEN         = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_W           = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [31:0]       cmd_adr,
  input  logic [3:0]        cmd_sel,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [31:0]       wr_data,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic              done,
  output logic              done_err,
  wb_burst_master_if.master wb
);

  localparam int               OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic [31:0]        adr_q, adr_d;          // address of the next beat
  logic [3:0]         sel_q, sel_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   issued_q, issued_d;
  logic [OUT_W-1:0]   outstanding_q, outstanding_d;
  logic               err_seen_q, err_seen_d;
  logic               done_q, done_d;
  logic               done_err_q, done_err_d;

  logic               cyc;
  logic               stb;
  logic               accept;
  logic               resp;
  logic [LEN_W-1:0]   len_sat;

  assign len_sat = (cmd_len > MAX_LEN_C) ? MAX_LEN_C : cmd_len;

  // Bus cycle is open for the whole command; a strobe needs a free slot,
  // remaining beats, no prior error and, for writes, data on hand.
  assign cyc    = (state_q != IDLE);
  assign stb    = (state_q == ISSUE) && (issued_q < len_q) &&
                  (outstanding_q < MAX_OUT_C) && !err_seen_q &&
                  (!we_q || wr_valid);
  assign accept = stb && !wb.stall;
  // Responses with nothing outstanding are stray and ignored.
  assign resp   = cyc && (wb.ack || wb.err) && (outstanding_q != '0);

  assign cmd_ready = (state_q == IDLE);
  assign wr_ready  = accept && we_q;
  assign rd_valid  = wb.ack && cyc && !we_q;
  assign rd_data   = wb.dat_i;
  assign done      = done_q;
  assign done_err  = done_err_q;

  assign wb.cyc   = cyc;
  assign wb.stb   = stb;
  assign wb.we    = cyc && we_q;
  assign wb.sel   = cyc ? sel_q : 4'h0;
  assign wb.adr   = cyc ? adr_q : 32'h0;
  assign wb.dat_o = stb ? wr_data : 32'h0;

  // Next-state and counter update for the command/issue/drain sequence.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    adr_d         = adr_q;
    sel_d         = sel_q;
    len_d         = len_q;
    issued_d      = issued_q;
    outstanding_d = outstanding_q;
    err_seen_d    = err_seen_q;
    done_d        = 1'b0;
    done_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d          = cmd_we;
          adr_d         = cmd_adr;
          sel_d         = cmd_sel;
          len_d         = len_sat;
          issued_d      = '0;
          outstanding_d = '0;
          err_seen_d    = 1'b0;
          // A zero-length command completes without touching the bus.
          if (len_sat == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      ISSUE, DRAIN: begin
        if (accept) begin
          issued_d = issued_q + LEN_W'(1);
          adr_d    = adr_q + 32'd4;
        end
        case ({accept, resp})
          2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
          2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
          default: outstanding_d = outstanding_q;
        endcase
        if (resp && wb.err) begin
          err_seen_d = 1'b1;
        end
        if ((state_q == ISSUE) && ((issued_d == len_q) || err_seen_d)) begin
          state_d = DRAIN;
        end
        // Close the cycle once the last response has been taken.
        if ((state_d == DRAIN) && (outstanding_d == '0)) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          done_err_d = err_seen_d;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and counter registers; reset abandons any burst in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      adr_q         <= 32'h0;
      sel_q         <= 4'h0;
      len_q         <= '0;
      issued_q      <= '0;
      outstanding_q <= '0;
      err_seen_q    <= 1'b0;
      done_q        <= 1'b0;
      done_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      adr_q         <= adr_d;
      sel_q         <= sel_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      outstanding_q <= outstanding_d;
      err_seen_q    <= err_seen_d;
      done_q        <= done_d;
      done_err_q    <= done_err_d;
    end
  end

endmodule
`default_nettype wire
